alarm_controller: RTL and testbench
===================================

ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter CLK_HZ, default 5000000: clock cycles per second.
REQ-002 Parameter SNOOZE_SECONDS, default 540: snooze duration.
REQ-003 Parameter RING_TIMEOUT_SECONDS, default 600: auto-silence after ringing this long.
REQ-004 Parameter TONE_HALF_PERIOD, default 2500: buzzer tone half-period in cycles (1 kHz at default).
REQ-005 Port i_Clk_5MHz, input, 1: single clock; all logic is on its rising edge.
REQ-006 Port i_Reset, input, 1: reset, asynchronous, active-low (0 = reset).
REQ-007 Port i_Clock_Time, input, 32: current time BCD {HH,MM,SS,FF}, 12-hour format.
REQ-008 Port i_Clock_PM, input, 1: current time PM flag.
REQ-009 Port i_Alarm_Time, input, 32: alarm time BCD {HH,MM,SS,FF}, as produced by the alarm-time stage.
REQ-010 Port i_Alarm_PM, input, 1: alarm PM flag.
REQ-011 Port i_Alarm_Enable, input, 1: level; alarm armed when 1.
REQ-012 Port i_Snooze, input, 1: single-cycle pulse, pre-debounced.
REQ-013 Port i_Stop, input, 1: single-cycle pulse, pre-debounced.
REQ-014 Port o_State, output, 2: IDLE=0, RINGING=1, SNOOZE=2.
REQ-015 Port o_Ringing, output, 1: high in RINGING.
REQ-016 Port o_Snoozing, output, 1: high in SNOOZE.
REQ-017 Port o_Buzzer, output, 1: gated tone drive.

Function
REQ-018 Match SHALL be {i_Clock_Time[31:16], i_Clock_PM} == {i_Alarm_Time[31:16], i_Alarm_PM}; seconds and hundredths are ignored.
REQ-019 A registered copy match_q SHALL hold the previous cycle's match; trigger = match & ~match_q & i_Alarm_Enable & (state == IDLE).
REQ-020 On trigger, state SHALL be RINGING from the next cycle (1-cycle latency); o_Ringing, o_State and o_Snoozing are registered and reflect the state directly.
REQ-021 A match held for a whole minute SHALL trigger at most once; triggers while in RINGING or SNOOZE are ignored.
REQ-022 RINGING: i_Stop -> IDLE; else i_Snooze -> SNOOZE; else i_Alarm_Enable = 0 -> IDLE; else timeout -> IDLE.
REQ-023 SNOOZE: i_Stop or i_Alarm_Enable = 0 -> IDLE; snooze expiry -> RINGING; i_Snooze is ignored.
REQ-024 i_Stop and i_Snooze asserted in the same cycle: i_Stop wins.
REQ-025 The prescaler (0..CLK_HZ-1) and the second counter SHALL clear on every entry to RINGING or SNOOZE; the prescaler emits a 1-cycle sec_tick at CLK_HZ-1.
REQ-026 Timeout: RINGING SHALL last exactly RING_TIMEOUT_SECONDS*CLK_HZ cycles if uninterrupted; snooze: SNOOZE lasts exactly SNOOZE_SECONDS*CLK_HZ cycles.
REQ-027 Second counter width SHALL be $clog2(max(SNOOZE_SECONDS, RING_TIMEOUT_SECONDS)+1); the counter never wraps.
REQ-028 The tone counter SHALL run only in RINGING, toggling tone_sq every TONE_HALF_PERIOD cycles, and clears (tone_sq = 0) otherwise.
REQ-029 o_Buzzer (registered) SHALL be tone_sq & (prescaler < CLK_HZ/2) & RINGING: beeping during the first half of each second, silent otherwise.

Reset
REQ-030 While i_Reset = 0: state IDLE, o_State = 0, o_Ringing = 0, o_Snoozing = 0, o_Buzzer = 0, all counters 0, match_q = 1 (so power-up with both times equal does not ring).
REQ-031 Reset mid-RINGING or mid-SNOOZE SHALL force the outputs low immediately, without waiting for a clock edge.

Structure
REQ-032 Package alarm_pkg SHALL hold the state encoding constants (IDLE/RINGING/SNOOZE) and the 2-bit state type.
REQ-033 The prescaler plus second counter SHALL be one sub-module, Tick_Generator (inputs: clear, enable; outputs: sec_tick, prescaler value, seconds).

Verification (CLK_HZ=10, TONE_HALF_PERIOD=1, SNOOZE_SECONDS=3, RING_TIMEOUT_SECONDS=5)
REQ-034 Release reset with both times 0x12000000 AM and enable=1 -> o_State stays 0 for 100 cycles.
REQ-035 Alarm 0x06300000 AM; clock steps 0x06295999 -> 0x06300000 -> o_Ringing = 1 exactly one cycle later, o_State = 1.
REQ-036 RINGING, i_Snooze pulse -> o_Snoozing = 1 next cycle and o_Buzzer = 0; after 30 cycles -> RINGING again; after 50 more cycles with clock still 06:30 -> IDLE with no re-trigger.
REQ-037 RINGING, i_Stop and i_Snooze in the same cycle -> o_State = 0 next cycle.
REQ-038 RINGING -> o_Buzzer toggles every cycle in prescaler counts 0-4 and is 0 in counts 5-9.
REQ-039 Assert i_Reset = 0 mid-SNOOZE -> all outputs 0 asynchronously; release while the times still match -> no ring.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: state encoding and helpers.
package alarm_pkg;

  // Encoding is visible on o_State, so the values are fixed.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  // Larger of two integers, used to size the seconds counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_controller_tick_generator.sv
// Prescaler plus seconds counter.
// sec_tick_o pulses for one cycle on the last prescaler count of each second.
// The seconds counter saturates rather than wrapping.
module Tick_Generator #(
  parameter int CLK_HZ      = 5000000,
  parameter int MAX_SECONDS = 600,
  parameter int PRESC_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1,
  parameter int SEC_W       = $clog2(MAX_SECONDS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               enable_i,
  output logic               sec_tick_o,
  output logic [PRESC_W-1:0] prescaler_o,
  output logic [PRESC_W-1:0] prescaler_next_o,
  output logic [SEC_W-1:0]   seconds_o
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SEC_W-1:0]   sec_q, sec_d;

  // Next-count logic: clear has priority, then counting while enabled.
  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    presc_d    = presc_q;
    sec_d      = sec_q;
    sec_tick_o = enable_i && (presc_q == PRESC_W'(CLK_HZ - 1));
    if (clear_i) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (enable_i) begin
      if (sec_tick_o) begin
        presc_d = '0;
        if (sec_q != SEC_W'(MAX_SECONDS)) sec_d = sec_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Counter registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sec_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
    end
  end

  assign prescaler_o      = presc_q;
  assign prescaler_next_o = presc_d;
  assign seconds_o        = sec_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: rings when the clock's hour/minute/PM match the alarm,
// supports snooze, stop and auto-silence, and drives a gated buzzer tone.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int CLK_HZ               = 5000000,
  parameter int SNOOZE_SECONDS       = 540,
  parameter int RING_TIMEOUT_SECONDS = 600,
  parameter int TONE_HALF_PERIOD     = 2500
) (
  input  logic        i_Clk_5MHz,
  input  logic        i_Reset,
  input  logic [31:0] i_Clock_Time,
  input  logic        i_Clock_PM,
  input  logic [31:0] i_Alarm_Time,
  input  logic        i_Alarm_PM,
  input  logic        i_Alarm_Enable,
  input  logic        i_Snooze,
  input  logic        i_Stop,
  output logic [1:0]  o_State,
  output logic        o_Ringing,
  output logic        o_Snoozing,
  output logic        o_Buzzer
);

  localparam int MAX_SECONDS = max_int(SNOOZE_SECONDS, RING_TIMEOUT_SECONDS);
  localparam int PRESC_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SEC_W       = $clog2(MAX_SECONDS + 1);
  localparam int TONE_W      = $clog2(TONE_HALF_PERIOD + 1);

  state_t              state_q, state_d;
  logic                match, match_q;
  logic                ringing_q, snoozing_q, buzzer_q, buzzer_d;
  logic                tone_q, tone_d;
  logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
  logic                tick_clear, tick_enable, sec_tick;
  logic [PRESC_W-1:0]  prescaler, prescaler_next;
  logic [SEC_W-1:0]    seconds;
  logic                ring_timeout, snooze_expire;

  // Only hours, minutes and PM take part in the match.
  assign match = ({i_Clock_Time[31:16], i_Clock_PM} == {i_Alarm_Time[31:16], i_Alarm_PM});

  // Last second of each phase ends on its final sec_tick.
  assign ring_timeout  = sec_tick && (seconds == SEC_W'(RING_TIMEOUT_SECONDS - 1));
  assign snooze_expire = sec_tick && (seconds == SEC_W'(SNOOZE_SECONDS - 1));

  // Timing restarts on every entry into RINGING or SNOOZE.
  assign tick_clear  = (state_d != state_q) && (state_d != IDLE);
  assign tick_enable = (state_q != IDLE);

  Tick_Generator #(
    .CLK_HZ     (CLK_HZ),
    .MAX_SECONDS(MAX_SECONDS),
    .PRESC_W    (PRESC_W),
    .SEC_W      (SEC_W)
  ) u_tick (
    .clk             (i_Clk_5MHz),
    .rst_n           (i_Reset),
    .clear_i         (tick_clear),
    .enable_i        (tick_enable),
    .sec_tick_o      (sec_tick),
    .prescaler_o     (prescaler),
    .prescaler_next_o(prescaler_next),
    .seconds_o       (seconds)
  );

  // Next-state logic; stop beats snooze, and edge-detected match arms a ring.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (match && !match_q && i_Alarm_Enable) state_d = RINGING;
      end
      RINGING: begin
        if (i_Stop)               state_d = IDLE;
        else if (i_Snooze)        state_d = SNOOZE;
        else if (!i_Alarm_Enable) state_d = IDLE;
        else if (ring_timeout)    state_d = IDLE;
      end
      SNOOZE: begin
        if (i_Stop || !i_Alarm_Enable) state_d = IDLE;
        else if (snooze_expire)        state_d = RINGING;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tone generator runs only while staying in RINGING; restarts low on entry.
  always_comb begin
    tone_cnt_d = '0;
    tone_d     = 1'b0;
    if (state_q == RINGING && state_d == RINGING) begin
      if (tone_cnt_q == TONE_W'(TONE_HALF_PERIOD - 1)) begin
        tone_d = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 1'b1;
        tone_d     = tone_q;
      end
    end
    // Computed from next-cycle values so the buzzer lines up with the prescaler it shows.
    buzzer_d = (state_d == RINGING) && tone_d && (prescaler_next < PRESC_W'(CLK_HZ / 2));
  end

  // State, match history and registered outputs.
  always_ff @(posedge i_Clk_5MHz or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q    <= IDLE;
      // Treat power-up as "already matching" so equal times at reset do not ring.
      match_q    <= 1'b1;
      tone_q     <= 1'b0;
      tone_cnt_q <= '0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_q    <= match;
      tone_q     <= tone_d;
      tone_cnt_q <= tone_cnt_d;
      ringing_q  <= (state_d == RINGING);
      snoozing_q <= (state_d == SNOOZE);
      buzzer_q   <= buzzer_d;
    end
  end

  assign o_State    = state_q;
  assign o_Ringing  = ringing_q;
  assign o_Snoozing = snoozing_q;
  assign o_Buzzer   = buzzer_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller with a small-time-scale configuration.
module tb_alarm_controller;

  localparam int CLK  = 10;
  localparam int THP  = 1;
  localparam int SNZ  = 3;
  localparam int RING = 5;

  localparam logic [31:0] T_0629 = 32'h06295999;
  localparam logic [31:0] T_0630 = 32'h06300000;

  logic        clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic [31:0] i_Clock_Time = 32'h12000000;
  logic        i_Clock_PM = 1'b0;
  logic [31:0] i_Alarm_Time = 32'h12000000;
  logic        i_Alarm_PM = 1'b0;
  logic        i_Alarm_Enable = 1'b1;
  logic        i_Snooze = 1'b0;
  logic        i_Stop = 1'b0;
  logic [1:0]  o_State;
  logic        o_Ringing, o_Snoozing, o_Buzzer;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0/1/2 = idle/ringing/snoozing, elapsed cycles in the current mode.
  int m_mode = 0;
  int m_el   = 0;
  bit m_prev = 1'b1;

  alarm_controller #(
    .CLK_HZ              (CLK),
    .SNOOZE_SECONDS      (SNZ),
    .RING_TIMEOUT_SECONDS(RING),
    .TONE_HALF_PERIOD    (THP)
  ) dut (
    .i_Clk_5MHz    (clk),
    .i_Reset       (i_Reset),
    .i_Clock_Time  (i_Clock_Time),
    .i_Clock_PM    (i_Clock_PM),
    .i_Alarm_Time  (i_Alarm_Time),
    .i_Alarm_PM    (i_Alarm_PM),
    .i_Alarm_Enable(i_Alarm_Enable),
    .i_Snooze      (i_Snooze),
    .i_Stop        (i_Stop),
    .o_State       (o_State),
    .o_Ringing     (o_Ringing),
    .o_Snoozing    (o_Snoozing),
    .o_Buzzer      (o_Buzzer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    bit exp_buz;
    exp_buz = (m_mode == 1) && (((m_el / THP) % 2) == 1) && ((m_el % CLK) < (CLK / 2));
    check("state",    {30'b0, o_State},  m_mode);
    check("ringing",  {31'b0, o_Ringing},  {31'b0, (m_mode == 1)});
    check("snoozing", {31'b0, o_Snoozing}, {31'b0, (m_mode == 2)});
    check("buzzer",   {31'b0, o_Buzzer},   {31'b0, exp_buz});
  endtask

  // One clock: model computes its next state from the inputs, DUT clocks, outputs compared at negedge.
  task automatic cycle();
    int  nmode, nel;
    bit  nprev, match;
    nmode = m_mode;
    nel   = m_el;
    if (!i_Reset) begin
      nmode = 0; nel = 0; nprev = 1'b1;
    end else begin
      match = (i_Clock_Time[31:16] == i_Alarm_Time[31:16]) && (i_Clock_PM == i_Alarm_PM);
      nprev = match;
      case (m_mode)
        0: if (match && !m_prev && i_Alarm_Enable) begin nmode = 1; nel = 0; end
        1: begin
          if (i_Stop)                       nmode = 0;
          else if (i_Snooze)                begin nmode = 2; nel = 0; end
          else if (!i_Alarm_Enable)         nmode = 0;
          else if (m_el == RING * CLK - 1)  nmode = 0;
          else                              nel = m_el + 1;
        end
        default: begin
          if (i_Stop || !i_Alarm_Enable)    nmode = 0;
          else if (m_el == SNZ * CLK - 1)   begin nmode = 1; nel = 0; end
          else                              nel = m_el + 1;
        end
      endcase
    end
    @(posedge clk);
    m_mode = nmode; m_el = nel; m_prev = nprev;
    @(negedge clk);
    check_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse(input bit snz, input bit stp);
    i_Snooze = snz; i_Stop = stp;
    cycle();
    i_Snooze = 1'b0; i_Stop = 1'b0;
  endtask

  initial begin
    // Power-up reset with equal times and the alarm armed.
    #1 i_Reset = 1'b0;
    @(negedge clk);
    check("reset_state", {30'b0, o_State}, 32'd0);
    check("reset_buzzer", {31'b0, o_Buzzer}, 32'd0);
    run(3);
    i_Reset = 1'b1;
    run(100);
    check("no_ring_after_reset", {30'b0, o_State}, 32'd0);

    // Minute rollover onto the alarm: rings one cycle later.
    i_Alarm_Time = T_0630;
    i_Clock_Time = T_0629;
    run(3);
    i_Clock_Time = T_0630;
    cycle();
    check("ring_latency", {31'b0, o_Ringing}, 32'd1);
    check("ring_state", {30'b0, o_State}, 32'd1);

    // Ring for a while (buzzer pattern checked every cycle), then snooze.
    run(24);
    pulse(1'b1, 1'b0);
    check("snooze_entry", {31'b0, o_Snoozing}, 32'd1);
    check("snooze_buzzer", {31'b0, o_Buzzer}, 32'd0);
    run(30);
    check("snooze_expire", {31'b0, o_Ringing}, 32'd1);
    run(50);
    check("ring_timeout", {30'b0, o_State}, 32'd0);
    run(20);
    check("no_retrigger", {30'b0, o_State}, 32'd0);

    // Stop and snooze together: stop wins.
    i_Clock_Time = T_0629;
    run(2);
    i_Clock_Time = T_0630;
    run(7);
    pulse(1'b1, 1'b1);
    check("stop_wins", {30'b0, o_State}, 32'd0);

    // Randomized phase: minute flips, PM flips, enable drops, random pulses.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 5)       i_Clock_Time = (i_Clock_Time[31:16] == 16'h0630) ? T_0629 : T_0630;
      else if (r == 5) i_Clock_PM   = ~i_Clock_PM;
      if (r >= 90)     i_Clock_Time[15:0] = 16'($urandom);
      i_Alarm_Enable = ($urandom_range(0, 149) != 0);
      i_Snooze       = ($urandom_range(0, 29) == 0);
      i_Stop         = ($urandom_range(0, 59) == 0);
      cycle();
    end
    i_Snooze = 1'b0; i_Stop = 1'b0; i_Alarm_Enable = 1'b1;
    i_Clock_PM = i_Alarm_PM;
    run(120);

    // Asynchronous reset in the middle of SNOOZE.
    i_Clock_Time = T_0629;
    run(2);
    i_Clock_Time = T_0630;
    run(5);
    pulse(1'b1, 1'b0);
    run(10);
    check("pre_reset_snooze", {31'b0, o_Snoozing}, 32'd1);
    #2 i_Reset = 1'b0;
    #1;
    check("async_state",    {30'b0, o_State},  32'd0);
    check("async_snoozing", {31'b0, o_Snoozing}, 32'd0);
    check("async_ringing",  {31'b0, o_Ringing},  32'd0);
    check("async_buzzer",   {31'b0, o_Buzzer},   32'd0);
    m_mode = 0; m_el = 0; m_prev = 1'b1;
    run(3);
    i_Reset = 1'b1;
    run(50);
    check("no_ring_after_release", {30'b0, o_State}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
